// File: rtl/store_data_packer_pkg.sv
// Shared definitions for the MEM-stage store path: op codes, transfer sizes,
// FSM state encoding and the base byte-strobe pattern per op.
package store_data_packer_pkg;

   typedef enum logic [1:0] {
      ST_SB  = 2'b00,
      ST_SH  = 2'b01,
      ST_SW  = 2'b10,
      ST_RSV = 2'b11
   } st_op_e;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } fsm_state_e;

   // Strobe pattern for a store that starts on lane 0; shifted by the byte offset later.
   function automatic logic [3:0] strb_base(input logic [1:0] op);
      case (op)
         ST_SB:   strb_base = 4'b0001;
         ST_SH:   strb_base = 4'b0011;
         ST_SW:   strb_base = 4'b1111;
         default: strb_base = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/store_data_packer_lane_pack.sv
// Combinational lane packer: replicates the GPR value across byte lanes and
// derives strobes, transfer size and the misalignment flag from op + addr[1:0].
module store_lane_pack
   import store_data_packer_pkg::*;
#(
   parameter int ALIGN_CHECK = 1
) (
   input  logic [1:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [1:0]  size,
   output logic [1:0]  addr_lo_eff,
   output logic        misaligned,
   output logic        op_ok
);

   logic raw_misaligned;

   always_comb begin
      op_ok          = (op != ST_RSV);
      size           = SIZE_B;
      raw_misaligned = 1'b0;
      addr_lo_eff    = addr_lo;
      case (op)
         ST_SH: begin
            size           = SIZE_H;
            raw_misaligned = addr_lo[0];
            if (ALIGN_CHECK == 0) addr_lo_eff = {addr_lo[1], 1'b0};
         end
         ST_SW: begin
            size           = SIZE_W;
            raw_misaligned = |addr_lo;
            if (ALIGN_CHECK == 0) addr_lo_eff = 2'b00;
         end
         default: ;
      endcase
      misaligned = (ALIGN_CHECK != 0) && raw_misaligned;
      wstrb      = strb_base(op) << addr_lo_eff;
   end

   // Each lane picks its source byte: SB always byte 0, SH alternates bytes 0/1.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wdata[8*gi +: 8] = (op == ST_SB) ? data[7:0] :
                                   (op == ST_SH) ? data[8*(gi%2) +: 8] :
                                                   data[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/store_data_packer.sv
// MEM-stage store engine: packs store data, drives the req/addr_ok/data_ok
// write handshake, stalls the pipeline until completion and flags AdES.
module store_data_packer
   import store_data_packer_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int ALIGN_CHECK = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              st_valid,
   input  logic [1:0]        st_op,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic              flush,
   output logic              st_stall,
   output logic              st_done,
   output logic              st_ades,
   output logic [ADDR_W-1:0] st_badvaddr,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [31:0]       data_wdata,
   output logic [3:0]        data_wstrb,
   input  logic              data_addr_ok,
   input  logic              data_data_ok
);

   logic [31:0] pack_wdata;
   logic [3:0]  pack_wstrb;
   logic [1:0]  pack_size;
   logic [1:0]  pack_addr_lo;
   logic        pack_misaligned;
   logic        pack_op_ok;

   store_lane_pack #(.ALIGN_CHECK(ALIGN_CHECK)) u_lane_pack (
      .op          (st_op),
      .addr_lo     (st_addr[1:0]),
      .data        (st_data),
      .wdata       (pack_wdata),
      .wstrb       (pack_wstrb),
      .size        (pack_size),
      .addr_lo_eff (pack_addr_lo),
      .misaligned  (pack_misaligned),
      .op_ok       (pack_op_ok)
   );

   fsm_state_e        state_reg;
   logic              data_req_reg;
   logic              st_done_reg;
   logic              complete_reg;
   logic              flushed_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [1:0]        size_reg;
   logic [31:0]       wdata_reg;
   logic [3:0]        wstrb_reg;
   logic              idle;
   logic              accept;

   assign idle = (state_reg == S_IDLE);

   // complete_reg blocks re-accepting the same store, which is still sitting in MEM
   // during the cycle stall drops.
   assign accept = st_valid & ~flush & idle & ~complete_reg & pack_op_ok & ~pack_misaligned;

   assign st_ades     = st_valid & ~flush & pack_misaligned & idle;
   assign st_badvaddr = st_ades ? st_addr : '0;
   assign st_stall    = accept | ~idle;
   assign st_done     = st_done_reg;

   assign data_req   = data_req_reg;
   assign data_wr    = data_req_reg;
   assign data_size  = size_reg;
   assign data_addr  = addr_reg;
   assign data_wdata = wdata_reg;
   assign data_wstrb = wstrb_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= S_IDLE;
         data_req_reg <= 1'b0;
         st_done_reg  <= 1'b0;
         complete_reg <= 1'b0;
         flushed_reg  <= 1'b0;
         addr_reg     <= '0;
         size_reg     <= '0;
         wdata_reg    <= '0;
         wstrb_reg    <= '0;
      end else begin
         st_done_reg  <= 1'b0;
         complete_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  state_reg    <= S_REQ;
                  data_req_reg <= 1'b1;
                  flushed_reg  <= 1'b0;
                  addr_reg     <= {st_addr[ADDR_W-1:2], pack_addr_lo};
                  size_reg     <= pack_size;
                  wdata_reg    <= pack_wdata;
                  wstrb_reg    <= pack_wstrb;
               end
            end
            S_REQ: begin
               // The request stays up until accepted even if a flush arrives.
               if (data_addr_ok && data_data_ok) begin
                  state_reg    <= S_IDLE;
                  data_req_reg <= 1'b0;
                  complete_reg <= 1'b1;
                  st_done_reg  <= ~(flushed_reg | flush);
                  flushed_reg  <= 1'b0;
               end else if (data_addr_ok) begin
                  state_reg    <= S_WAIT;
                  data_req_reg <= 1'b0;
                  flushed_reg  <= flushed_reg | flush;
               end else begin
                  flushed_reg  <= flushed_reg | flush;
               end
            end
            S_WAIT: begin
               if (data_data_ok) begin
                  state_reg    <= S_IDLE;
                  complete_reg <= 1'b1;
                  st_done_reg  <= ~(flushed_reg | flush);
                  flushed_reg  <= 1'b0;
               end else begin
                  flushed_reg  <= flushed_reg | flush;
               end
            end
            default: begin
               state_reg    <= S_IDLE;
               data_req_reg <= 1'b0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // data_ok with no accepted request outstanding is a slave protocol violation.
   always @(posedge clk) begin
      if (resetn) begin
         assert (!(data_data_ok && (idle || (state_reg == S_REQ && !data_addr_ok))))
            else $error("data_data_ok without an accepted request");
      end
   end
`endif

endmodule

// File: tb/tb_store_data_packer.sv
// Scoreboard bench for store_data_packer: a driver issues stores and pushes the
// expected bus requests; a monitor pops and compares them as the DUT presents them.
module tb_store_data_packer;

   logic        clk;
   logic        resetn;
   logic        st_valid;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        flush;
   logic        st_stall;
   logic        st_done;
   logic        st_ades;
   logic [31:0] st_badvaddr;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok;
   logic        data_data_ok;

   store_data_packer #(.ADDR_W(32), .ALIGN_CHECK(1)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .st_valid     (st_valid),
      .st_op        (st_op),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .flush        (flush),
      .st_stall     (st_stall),
      .st_done      (st_done),
      .st_ades      (st_ades),
      .st_badvaddr  (st_badvaddr),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_wstrb   (data_wstrb),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      bit          done;
   } req_t;

   req_t req_q[$];
   bit   out_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cur_addr_delay = 0;
   int   cur_data_delay = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_misaligned(input logic [1:0] op, input logic [31:0] a);
      return (op == 2'd1 && (a % 2) != 0) || (op == 2'd2 && (a % 4) != 0);
   endfunction

   // Reference: byte replication by multiplication, strobes by shifting a lane mask.
   function automatic req_t model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] d, input bit done);
      req_t r;
      int   off;
      off     = int'(a % 4);
      r.addr  = a;
      r.size  = op;
      r.done  = done;
      if (op == 2'd0) begin
         r.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
         r.wstrb = 4'(1 << off);
      end else if (op == 2'd1) begin
         r.wdata = {16'd0, d[15:0]} * 32'h0001_0001;
         r.wstrb = 4'(3 << off);
      end else begin
         r.wdata = d;
         r.wstrb = 4'hF;
      end
      return r;
   endfunction

   // Slave: addr_ok after cur_addr_delay extra request cycles, data_ok cur_data_delay later.
   initial begin
      int req_wait_cnt;
      int wait_cnt;
      req_wait_cnt = 0;
      wait_cnt     = 0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         data_addr_ok = 1'b0;
         data_data_ok = 1'b0;
         if (!resetn) begin
            req_wait_cnt = 0;
            wait_cnt     = 0;
         end else if (data_req) begin
            if (req_wait_cnt < cur_addr_delay) begin
               req_wait_cnt++;
            end else begin
               req_wait_cnt = 0;
               data_addr_ok = 1'b1;
               if (cur_data_delay == 0) data_data_ok = 1'b1;
               else wait_cnt = cur_data_delay;
            end
         end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) data_data_ok = 1'b1;
         end
      end
   end

   // Monitor: request fields against the scoreboard, st_done one cycle after data_ok.
   initial begin
      bit   done_exp;
      bit   complete;
      req_t e;
      done_exp = 1'b0;
      complete = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            done_exp = 1'b0;
            complete = 1'b0;
         end else begin
            chk("st_done", st_done, done_exp);
            if (complete) chk("stall_in_done_cycle", st_stall, 0);
            done_exp = 1'b0;
            complete = 1'b0;
            if (data_req) begin
               if (req_q.size() == 0) begin
                  chk("spurious_req", data_req, 0);
               end else begin
                  e = req_q[0];
                  chk("req_addr", data_addr, e.addr);
                  chk("req_size", data_size, e.size);
                  chk("req_wdata", data_wdata, e.wdata);
                  chk("req_wstrb", data_wstrb, e.wstrb);
                  chk("req_wr", data_wr, 1);
                  if (data_addr_ok) begin
                     void'(req_q.pop_front());
                     out_q.push_back(e.done);
                     $display("req   addr=%h size=%0d wdata=%h wstrb=%b", data_addr, data_size,
                              data_wdata, data_wstrb);
                  end
               end
            end
            if (data_data_ok && out_q.size() > 0) begin
               complete = 1'b1;
               done_exp = out_q.pop_front();
            end
         end
      end
   end

   task automatic store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                        input int ad, input int dd, input bit fl_wait, input bit fl_idle);
      bit accepted;
      bit misal;
      bit flushed;
      bit do_flush;
      bit left;
      int cycles;
      cur_addr_delay = ad;
      cur_data_delay = dd;
      misal    = is_misaligned(op, a);
      accepted = (op != 2'd3) && !misal && !fl_idle;
      @(posedge clk);
      #1;
      st_valid = 1'b1;
      st_op    = op;
      st_addr  = a;
      st_data  = d;
      flush    = fl_idle;
      if (accepted) req_q.push_back(model(op, a, d, !fl_wait));
      $display("store op=%0d addr=%h data=%h ad=%0d dd=%0d flw=%0d fli=%0d", op, a, d, ad, dd,
               fl_wait, fl_idle);
      @(negedge clk);
      chk("st_ades", st_ades, (op != 2'd3) && misal && !fl_idle);
      chk("st_badvaddr", st_badvaddr, ((op != 2'd3) && misal && !fl_idle) ? a : 32'd0);
      chk("accept_stall", st_stall, accepted);
      if (accepted) begin
         cycles  = 1;
         flushed = 1'b0;
         left    = 1'b0;
         for (int k = 0; k < 100; k++) begin
            do_flush = fl_wait && !flushed && data_req && data_addr_ok && !data_data_ok;
            @(posedge clk);
            #1;
            flush = do_flush;
            if (do_flush) flushed = 1'b1;
            @(negedge clk);
            if (!st_stall) begin
               left = 1'b1;
               break;
            end
            cycles++;
         end
         if (!left) chk("stall_timeout", 1, 0);
         chk("stall_cycles", cycles, 2 + ad + dd);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         st_valid = 1'b0;
         flush    = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn   = 1'b0;
      st_valid = 1'b0;
      st_op    = 2'd0;
      st_addr  = 32'd0;
      st_data  = 32'd0;
      flush    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", data_req, 0);
      chk("rst_stall", st_stall, 0);
      chk("rst_done", st_done, 0);
      chk("rst_wdata", data_wdata, 0);
      chk("rst_addr", data_addr, 0);
      chk("rst_wstrb", data_wstrb, 0);
      #2 resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_req", data_req, 0);
      chk("post_rst_size", data_size, 0);

      store(2'd0, 32'h0000_1003, 32'h1234_5678, 0, 0, 0, 0);
      idle_cycles(2);
      store(2'd1, 32'h0000_2002, 32'hAABB_CCDD, 2, 2, 0, 0);
      idle_cycles(1);
      store(2'd2, 32'h0000_3001, 32'hDEAD_BEEF, 0, 0, 0, 0);
      idle_cycles(1);
      store(2'd2, 32'h0000_4000, 32'h0BAD_F00D, 0, 3, 1, 0);
      idle_cycles(1);
      store(2'd3, 32'h0000_4100, 32'h1111_2222, 0, 0, 0, 0);
      store(2'd2, 32'h0000_4200, 32'h3333_4444, 0, 0, 0, 1);
      idle_cycles(1);

      // Reset while the request is still waiting for addr_ok.
      cur_addr_delay = 10;
      cur_data_delay = 0;
      @(posedge clk);
      #1;
      st_valid = 1'b1;
      st_op    = 2'd2;
      st_addr  = 32'h0000_5000;
      st_data  = 32'h5555_AAAA;
      req_q.push_back(model(2'd2, 32'h0000_5000, 32'h5555_AAAA, 1'b1));
      @(negedge clk);
      chk("rst_test_accept", st_stall, 1);
      @(negedge clk);
      chk("rst_test_req_up", data_req, 1);
      #2;
      resetn   = 1'b0;
      st_valid = 1'b0;
      #1;
      chk("rst_test_req_drop", data_req, 0);
      chk("rst_test_stall", st_stall, 0);
      req_q.delete();
      out_q.delete();
      @(negedge clk);
      #2 resetn = 1'b1;
      store(2'd1, 32'h0000_6006, 32'hCAFE_BABE, 1, 1, 0, 0);

      store(2'd0, 32'h0000_7001, 32'h0000_00A5, 0, 0, 0, 0);
      store(2'd2, 32'h0000_7004, 32'h0102_0304, 1, 0, 0, 0);

      for (int n = 0; n < 60; n++) begin
         logic [1:0]  op;
         logic [31:0] a;
         int          ad;
         int          dd;
         bit          fw;
         bit          fi;
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (op == 2'd2) a[1:0] = 2'b00;
            if (op == 2'd1) a[0] = 1'b0;
         end
         ad = $urandom_range(0, 3);
         dd = $urandom_range(0, 3);
         fw = (dd >= 2) && ($urandom_range(0, 4) == 0);
         fi = ($urandom_range(0, 9) == 0);
         store(op, a, $urandom, ad, dd, fw, fi);
         if ($urandom_range(0, 1) != 0) idle_cycles($urandom_range(1, 2));
      end

      idle_cycles(4);
      @(negedge clk);
      chk("req_q_empty", req_q.size(), 0);
      chk("out_q_empty", out_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
